// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and widths for the SPI transfer master
package spi_pkg;
  localparam int DW = 16;
  localparam int LW = 5;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, DONE} state_t;
endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period tick generator, restarts whenever it is enabled
module spi_clkgen #(
  parameter int DIV_HALF = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_en,
  output logic o_tick
);
  logic [7:0] r_cnt;
  // tick on the last cycle of each half period while enabled
  always_comb o_tick = i_en && (r_cnt == 8'(DIV_HALF - 1));
  // counter holds at zero while disabled and wraps on every tick so consecutive phases stay DIV_HALF long
  always_ff @(posedge clock) r_cnt <= (reset || !i_en || o_tick) ? '0 : r_cnt + 8'd1;
endmodule

// File: rtl/spi_xfer_master.sv
// spi_xfer_master: single-transfer SPI mode-0 master with request/response handshakes
module spi_xfer_master
  import spi_pkg::*;
#(
  parameter int DIV_HALF = 2,
  parameter int MAX_LEN  = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] tx_data,
  input  logic [LW-1:0] len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rx_data,
  output logic          sck,
  output logic          ss,
  output logic          mosi,
  input  logic          miso
);
  state_t        r_state, w_next;
  logic [DW-1:0] r_tx, r_rx;
  logic [LW-1:0] r_len, r_bits, w_len, w_sh;
  logic          w_accept, w_en, w_tick;
  spi_clkgen #(.DIV_HALF(DIV_HALF)) u_clkgen (
    .clock (clock),
    .reset (reset),
    .i_en  (w_en),
    .o_tick(w_tick)
  );
  // state register
  always_ff @(posedge clock) r_state <= reset ? IDLE : w_next;
  // each timed phase lasts one tick; LOW loops back to HIGH until every bit is exchanged
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? SETUP : IDLE;
      SETUP:   w_next = w_tick ? HIGH : SETUP;
      HIGH:    w_next = w_tick ? LOW : HIGH;
      LOW:     w_next = w_tick ? (r_bits < r_len ? HIGH : HOLD) : LOW;
      HOLD:    w_next = w_tick ? DONE : HOLD;
      DONE:    w_next = rsp_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // outputs decoded from state; mosi and sck are forced idle whenever the slave is deselected
  always_comb begin
    req_ready = (r_state == IDLE) && !reset;
    rsp_valid = (r_state == DONE) && !reset;
    ss        = !(r_state inside {SETUP, HIGH, LOW, HOLD});
    sck       = (r_state == HIGH);
    mosi      = ss || r_tx[DW-1];
    rx_data   = r_rx;
    w_en      = !ss;
    w_accept  = req_valid && req_ready;
    w_len     = (len == '0 || 32'(len) > MAX_LEN) ? LW'(MAX_LEN) : len;
    w_sh      = LW'(DW) - w_len;
  end
  // tx is left-aligned on accept so the next bit is always the MSB; both shifts happen on SCK fall
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx   <= '0;
      r_rx   <= '0;
      r_len  <= '0;
      r_bits <= '0;
    end else if (w_accept) begin
      r_tx   <= tx_data << w_sh;
      r_rx   <= '0;
      r_len  <= w_len;
      r_bits <= '0;
    end else if (r_state == HIGH && w_tick) begin
      r_tx   <= r_tx << 1;
      r_rx   <= {r_rx[DW-2:0], miso};
      r_bits <= r_bits + LW'(1);
    end
  end
endmodule

// File: tb/tb_spi_xfer_master.sv
// tb_spi_xfer_master: scoreboard bench running three DIV_HALF variants against bitrev and loopback slaves
module tb_spi_xfer_master;
  logic clk;
  int n_chk, n_fail, n_done;
  typedef struct {bit lb; logic [15:0] tx; logic [4:0] len; logic [15:0] exp; int hold; bit rst;} item_t;
  typedef struct {logic [15:0] rx; int L;} exp_t;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic void chk(string nm, int d, logic [31:0] act, logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s (DIV_HALF=%0d): got 0x%0h, expected 0x%0h", nm, d, act, want);
    end
  endfunction
  function automatic int eff(logic [4:0] l);
    return (l == 0 || l > 16) ? 16 : int'(l);
  endfunction
  function automatic logic [15:0] loop_model(logic [15:0] tx, int L);
    return tx & 16'((32'd1 << L) - 1);
  endfunction
  // slave replies 0x80 for the first byte, then each byte it received with its bit order reversed
  function automatic logic [15:0] bitrev_model(logic [15:0] tx, int L);
    logic [15:0] s, r;
    s = '0;
    r = '0;
    for (int i = 0; i < L; i++) s[i] = tx[L-1-i];
    for (int i = 0; i < L; i++) r[L-1-i] = (i < 8) ? (i == 0) : s[8*(i/8) - 1 - i%8];
    return r;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int D = g + 1;
    logic reset, req_valid, req_ready, rsp_valid, rsp_ready, sck, ss, mosi, miso, lb, s_miso;
    logic [15:0] tx_data, rx_data;
    logic [4:0] len;
    exp_t q[$];
    logic [7:0] reply, rcv;
    int k;
    int ncyc, acc, sslow, sckr;
    logic psck, seen, phs;
    logic [15:0] hrx;
    assign miso = lb ? mosi : s_miso;
    spi_xfer_master #(.DIV_HALF(D)) dut (
      .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .tx_data(tx_data), .len(len), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rx_data(rx_data), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
    );
    initial begin
      s_miso = 1;
      forever begin
        @(negedge ss);
        k = 0;
        reply = 8'h80;
        rcv = '0;
        s_miso = reply[7];
        while (!ss) begin
          @(posedge sck or posedge ss);
          if (ss) break;
          rcv = {rcv[6:0], mosi};
          k++;
          if (k % 8 == 0) for (int i = 0; i < 8; i++) reply[i] = rcv[7-i];
          @(negedge sck or posedge ss);
          if (ss) break;
          s_miso = reply[7 - k % 8];
        end
        s_miso = 1;
      end
    end
    initial begin
      ncyc = 0; acc = 0; sslow = 0; sckr = 0; psck = 0; seen = 0; phs = 0; hrx = '0;
      forever begin
        @(negedge clk);
        if (reset) begin
          seen = 0;
          phs = 0;
          psck = 0;
        end else begin
          ncyc++;
          if (phs) chk("req_ready_after_rsp", D, req_ready, 1);
          phs = 0;
          if (ss) chk("idle_sck_mosi", D, {sck, mosi}, 2'b01);
          if (req_valid && req_ready) begin
            acc = ncyc;
            sslow = 0;
            sckr = 0;
          end else begin
            sslow += int'(!ss);
            sckr += int'(sck && !psck);
          end
          psck = sck;
          if (rsp_valid) begin
            chk("req_ready_in_done", D, req_ready, 0);
            if (!seen) begin
              seen = 1;
              hrx = rx_data;
              if (q.size() == 0) chk("unexpected_rsp", D, rsp_valid, 0);
              else begin
                chk("latency", D, ncyc - acc, (2*q[0].L + 2)*D + 1);
                chk("sck_rises", D, sckr, q[0].L);
                chk("ss_low_cycles", D, sslow, (2*q[0].L + 2)*D);
              end
            end else chk("rx_stable", D, rx_data, hrx);
            if (rsp_ready) begin
              if (q.size() != 0) begin
                chk("rx_data", D, rx_data, q[0].rx);
                void'(q.pop_front());
              end
              seen = 0;
              phs = 1;
            end
          end else if (seen) begin
            chk("rsp_held", D, rsp_valid, 1);
            seen = 0;
          end
        end
      end
    end
    initial begin
      item_t items[$];
      item_t it;
      exp_t ex;
      int w, hc, e;
      bit got;
      logic ps;
      reset = 1; req_valid = 0; rsp_ready = 1; lb = 0; tx_data = '0; len = '0;
      items.push_back(item_t'{0, 16'h1300, 5'd16, 16'h80C8, 0, 0});
      items.push_back(item_t'{0, 16'h0100, 5'd16, 16'h8080, 0, 0});
      items.push_back(item_t'{1, 16'h0015, 5'd5, 16'h0015, 0, 0});
      items.push_back(item_t'{1, 16'hBEEF, 5'd0, 16'hBEEF, 0, 0});
      items.push_back(item_t'{1, 16'hBEEF, 5'd20, 16'hBEEF, 0, 0});
      items.push_back(item_t'{1, 16'hA5C3, 5'd1, 16'h0001, 10, 0});
      items.push_back(item_t'{0, 16'h1234, 5'd16, 16'h0000, 0, 1});
      items.push_back(item_t'{0, 16'h0100, 5'd16, 16'h8080, 0, 0});
      for (int n = 0; n < 12; n++) begin
        it.lb = 1'($urandom_range(0, 1));
        it.tx = 16'($urandom);
        it.len = 5'($urandom_range(0, 31));
        it.hold = $urandom_range(0, 3);
        it.rst = 0;
        it.exp = it.lb ? loop_model(it.tx, eff(it.len)) : bitrev_model(it.tx, eff(it.len));
        items.push_back(it);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", D, req_ready, 0);
      chk("rst_ss", D, ss, 1);
      chk("rst_sck", D, sck, 0);
      chk("rst_mosi", D, mosi, 1);
      chk("rst_rsp_valid", D, rsp_valid, 0);
      chk("rst_rx_data", D, rx_data, 0);
      @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("req_ready_after_reset", D, req_ready, 1);
      @(posedge clk);
      #1;
      foreach (items[n]) begin
        it = items[n];
        lb = it.lb; req_valid = 1; tx_data = it.tx; len = it.len; rsp_ready = (it.hold == 0);
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!req_ready && w < 200);
        chk("accept", D, req_ready, 1);
        if (!it.rst) begin
          ex.rx = it.exp;
          ex.L = eff(it.len);
          q.push_back(ex);
        end
        @(posedge clk);
        #1;
        req_valid = 0; tx_data = 16'($urandom); len = 5'($urandom);
        if (it.rst) begin
          e = 0; ps = 0; w = 0;
          while (e < 5 && w < 500) begin
            @(negedge clk);
            w++;
            if (sck && !ps) e++;
            ps = sck;
          end
          chk("sck_edges_before_reset", D, e, 5);
          @(posedge clk);
          #1 reset = 1;
          @(posedge clk);
          #1 reset = 0;
          @(negedge clk);
          chk("abort_ss", D, ss, 1);
          chk("abort_sck", D, sck, 0);
          chk("abort_mosi", D, mosi, 1);
          e = 0;
          repeat (40*D) begin
            @(negedge clk);
            e += int'(rsp_valid);
          end
          chk("abort_no_rsp", D, e, 0);
          @(posedge clk);
          #1;
        end else begin
          hc = 0; w = 0; got = 0;
          while (!got && w < 4000) begin
            @(negedge clk);
            w++;
            got = rsp_valid && rsp_ready;
            if (rsp_valid && !rsp_ready) hc++;
            @(posedge clk);
            #1;
            if (hc >= it.hold) rsp_ready = 1;
          end
          chk("rsp_handshake", D, got, 1);
        end
      end
      n_done++;
    end
  end
  initial begin
    int t;
    n_chk = 0;
    n_fail = 0;
    n_done = 0;
    t = 0;
    while (n_done < 3 && t < 90000) begin
      @(posedge clk);
      t++;
    end
    chk("all_instances_done", 0, n_done, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
